// File: rtl/ps2_hid_multi_pkg.sv
// Shared scan codes, HID bit positions, frame FSM states and the key map
// for the PS/2 to arcade-HID converter.
package ps2_hid_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_REL   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  // Arrow keys with E0, keypad 8/2/4/6 without
  localparam logic [7:0] SC_UP = 8'h75, SC_DW = 8'h72, SC_LF = 8'h6B, SC_RG = 8'h74;

  localparam logic [7:0] SC_F = 8'h2B, SC_D = 8'h23, SC_S = 8'h1B, SC_A = 8'h1C;
  localparam logic [7:0] SC_V = 8'h2A, SC_C = 8'h21, SC_X = 8'h22, SC_Z = 8'h1A;
  localparam logic [7:0] SC_1 = 8'h16, SC_2 = 8'h1E, SC_3 = 8'h26, SC_4 = 8'h25;

  localparam logic [7:0] SC_Q = 8'h15, SC_W = 8'h1D, SC_E = 8'h24, SC_R = 8'h2D;
  localparam logic [7:0] SC_U = 8'h3C, SC_I = 8'h43, SC_O = 8'h44, SC_P = 8'h4D;
  localparam logic [7:0] SC_5 = 8'h2E, SC_6 = 8'h36, SC_7 = 8'h3D, SC_8 = 8'h3E;

  localparam logic [3:0] IDX_UP = 4'd0,  IDX_DW = 4'd1,  IDX_LF = 4'd2,  IDX_RG = 4'd3;
  localparam logic [3:0] IDX_T0 = 4'd4,  IDX_T1 = 4'd5,  IDX_T2 = 4'd6,  IDX_T3 = 4'd7;
  localparam logic [3:0] IDX_T4 = 4'd8,  IDX_T5 = 4'd9,  IDX_T6 = 4'd10, IDX_T7 = 4'd11;
  localparam logic [3:0] IDX_S1 = 4'd12, IDX_S2 = 4'd13, IDX_CR = 4'd14, IDX_RS = 4'd15;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_state_t;

  typedef struct packed {
    logic       hit;
    logic       player;
    logic [3:0] idx;
  } key_hit_t;

  function automatic key_hit_t key_at(input logic player, input logic [3:0] idx);
    key_hit_t k;
    k.hit    = 1'b1;
    k.player = player;
    k.idx    = idx;
    return k;
  endfunction

  function automatic key_hit_t map_key(input logic ext, input logic [7:0] code,
                                       input logic two_players);
    key_hit_t m;
    // NOTE: default the whole result first so no path leaves it unassigned (no latch).
    m = '0;
    if (ext) begin
      case (code)
        SC_UP:   m = key_at(1'b0, IDX_UP);
        SC_DW:   m = key_at(1'b0, IDX_DW);
        SC_LF:   m = key_at(1'b0, IDX_LF);
        SC_RG:   m = key_at(1'b0, IDX_RG);
        default: m = '0;
      endcase
    end else begin
      case (code)
        // Keypad directions belong to player 1, or to player 0 in a one-player build
        SC_UP:   m = key_at(two_players, IDX_UP);
        SC_DW:   m = key_at(two_players, IDX_DW);
        SC_LF:   m = key_at(two_players, IDX_LF);
        SC_RG:   m = key_at(two_players, IDX_RG);
        SC_F:    m = key_at(1'b0, IDX_T7);
        SC_D:    m = key_at(1'b0, IDX_T6);
        SC_S:    m = key_at(1'b0, IDX_T5);
        SC_A:    m = key_at(1'b0, IDX_T4);
        SC_V:    m = key_at(1'b0, IDX_T3);
        SC_C:    m = key_at(1'b0, IDX_T2);
        SC_X:    m = key_at(1'b0, IDX_T1);
        SC_Z:    m = key_at(1'b0, IDX_T0);
        SC_1:    m = key_at(1'b0, IDX_S1);
        SC_2:    m = key_at(1'b0, IDX_S2);
        SC_3:    m = key_at(1'b0, IDX_CR);
        SC_4:    m = key_at(1'b0, IDX_RS);
        SC_Q:    m = key_at(1'b1, IDX_T7);
        SC_W:    m = key_at(1'b1, IDX_T6);
        SC_E:    m = key_at(1'b1, IDX_T5);
        SC_R:    m = key_at(1'b1, IDX_T4);
        SC_U:    m = key_at(1'b1, IDX_T3);
        SC_I:    m = key_at(1'b1, IDX_T2);
        SC_O:    m = key_at(1'b1, IDX_T1);
        SC_P:    m = key_at(1'b1, IDX_T0);
        SC_5:    m = key_at(1'b1, IDX_S1);
        SC_6:    m = key_at(1'b1, IDX_S2);
        SC_7:    m = key_at(1'b1, IDX_CR);
        SC_8:    m = key_at(1'b1, IDX_RS);
        default: m = '0;
      endcase
    end
    if (m.player && !two_players) m.hit = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/ps2_hid_multi_rx_frame.sv
// PS/2 receiver: pin synchroniser, falling-edge detect, 11-bit frame FSM
// with start/parity/stop validation and a stalled-frame timeout.
module ps2_rx_frame
  import ps2_hid_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       rx_err
);

  localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 17) ? $clog2(TIMEOUT_CYC + 1) : 17;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   dat_s;

  frame_state_t state;
  logic [2:0]   bit_cnt;
  logic [7:0]   shreg;
  logic         parity;
  logic [TW-1:0] tcnt;

  assign dat_s   = dat_sync[SYNC_STAGES-1];
  assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign rx_byte = shreg;

  // Lines idle high, so the chain resets to ones to avoid a false edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      parity     <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
      if (fall) begin
        // An edge always beats a coincident timeout
        tcnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!dat_s) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            parity <= dat_s;
            state  <= ST_STOP;
          end
          ST_STOP: begin
            if ((^{shreg, parity}) && dat_s) byte_valid <= 1'b1;
            else                             rx_err     <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          state  <= ST_IDLE;
          rx_err <= 1'b1;
          tcnt   <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_hid_multi.sv
// PS/2 keyboard to arcade-HID converter: frame receiver, E0/F0/E1 prefix
// decoder, per-player key map and active-low button registers.
module ps2_hid_multi
  import ps2_hid_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ps2_clk,
  input  logic                      ps2_dat,
  output logic [16*NUM_PLAYERS-1:0] hidout_n,
  output logic [3:0]                hidfunc,
  output logic                      rx_err
);

  logic [7:0]                rx_byte;
  logic                      byte_valid;
  logic                      ext;
  logic                      rel;
  logic [2:0]                skip;
  logic [16*NUM_PLAYERS-1:0] hid;
  logic [15:0]               p0;
  logic [4:0]                sel;
  key_hit_t                  key;

  ps2_rx_frame #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .rx_err    (rx_err)
  );

  assign key = map_key(ext, rx_byte, NUM_PLAYERS == 2);
  assign sel = {key.player, key.idx};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext  <= 1'b0;
      rel  <= 1'b0;
      skip <= 3'd0;
      hid  <= '0;
    end else if (rx_err) begin
      // A broken frame may have eaten a key byte, so drop any pending prefix
      ext <= 1'b0;
      rel <= 1'b0;
    end else if (byte_valid) begin
      if (skip != 3'd0) begin
        skip <= skip - 3'd1;
      end else if (rx_byte == SC_PAUSE) begin
        skip <= 3'd7;
      end else if (rx_byte == SC_EXT) begin
        ext <= 1'b1;
      end else if (rx_byte == SC_REL) begin
        rel <= 1'b1;
      end else begin
        for (int i = 0; i < 16*NUM_PLAYERS; i++) begin
          if (key.hit && int'(sel) == i) hid[i] <= ~rel;
        end
        ext <= 1'b0;
        rel <= 1'b0;
      end
    end
  end

  assign hidout_n = ~hid;
  assign p0       = hid[15:0];
  assign hidfunc  = {4{p0[IDX_RS]}} &
                    {p0[IDX_T5], p0[IDX_T6], p0[IDX_T7], ~(p0[IDX_T5] | p0[IDX_T6] | p0[IDX_T7])};

endmodule

// File: tb/tb_ps2_hid_multi.sv
// Self-checking bench for ps2_hid_multi: directed scenarios plus random
// scan-code streams compared against a table-driven keyboard model.
module tb_ps2_hid_multi;

  localparam int NP   = 2;
  localparam int TO   = 300;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [31:0] hidout_n;
  logic [3:0]  hidfunc;
  logic        rx_err;

  ps2_hid_multi #(
    .NUM_PLAYERS(NP),
    .TIMEOUT_CYC(TO),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .hidout_n(hidout_n),
    .hidfunc (hidfunc),
    .rx_err  (rx_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Keyboard map: (E0 prefix, scan code) -> pressed-bit position in the 32-bit vector
  typedef struct {
    bit         ext;
    logic [7:0] code;
    int         pos;
  } map_ent_t;

  map_ent_t tbl [32] = '{
    '{1'b1, 8'h75, 0},  '{1'b1, 8'h72, 1},  '{1'b1, 8'h6B, 2},  '{1'b1, 8'h74, 3},
    '{1'b0, 8'h1A, 4},  '{1'b0, 8'h22, 5},  '{1'b0, 8'h21, 6},  '{1'b0, 8'h2A, 7},
    '{1'b0, 8'h1C, 8},  '{1'b0, 8'h1B, 9},  '{1'b0, 8'h23, 10}, '{1'b0, 8'h2B, 11},
    '{1'b0, 8'h16, 12}, '{1'b0, 8'h1E, 13}, '{1'b0, 8'h26, 14}, '{1'b0, 8'h25, 15},
    '{1'b0, 8'h75, 16}, '{1'b0, 8'h72, 17}, '{1'b0, 8'h6B, 18}, '{1'b0, 8'h74, 19},
    '{1'b0, 8'h4D, 20}, '{1'b0, 8'h44, 21}, '{1'b0, 8'h43, 22}, '{1'b0, 8'h3C, 23},
    '{1'b0, 8'h2D, 24}, '{1'b0, 8'h24, 25}, '{1'b0, 8'h1D, 26}, '{1'b0, 8'h15, 27},
    '{1'b0, 8'h2E, 28}, '{1'b0, 8'h36, 29}, '{1'b0, 8'h3D, 30}, '{1'b0, 8'h3E, 31}
  };

  logic [31:0] exp_hid = '0;
  bit          m_ext = 1'b0;
  bit          m_rel = 1'b0;
  int          m_skip = 0;
  int          exp_err = 0;

  function automatic int lookup(input bit ext, input logic [7:0] code);
    for (int i = 0; i < 32; i++)
      if (tbl[i].ext == ext && tbl[i].code == code) return tbl[i].pos;
    return -1;
  endfunction

  function automatic logic [3:0] exp_func(input logic [31:0] h);
    logic t5, t6, t7;
    t5 = h[9]; t6 = h[10]; t7 = h[11];
    return h[15] ? {t5, t6, t7, ~(t5 | t6 | t7)} : 4'h0;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int pos;
    if (m_skip > 0)        m_skip--;
    else if (b == 8'hE1)   m_skip = 7;
    else if (b == 8'hE0)   m_ext = 1'b1;
    else if (b == 8'hF0)   m_rel = 1'b1;
    else begin
      pos = lookup(m_ext, b);
      if (pos >= 0) exp_hid[pos] = !m_rel;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  int   err_pulses = 0;
  int   long_pulses = 0;
  logic err_prev = 1'b0;

  always @(negedge clk) begin
    if (rx_err) err_pulses++;
    if (rx_err && err_prev) long_pulses++;
    err_prev = rx_err;
  end

  task automatic ps2_bit(input logic d);
    ps2_dat = d;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int n);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    send_bits(b, bad_par, 11);
    repeat (4) @(negedge clk);
    if (bad_par) begin
      m_ext = 1'b0;
      m_rel = 1'b0;
      exp_err++;
    end else begin
      model_byte(b);
    end
    check($sformatf("hid_after_%02h", b), hidout_n, ~exp_hid);
    check($sformatf("func_after_%02h", b), {28'h0, hidfunc}, {28'h0, exp_func(exp_hid)});
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int lat;
    int r;
    logic [7:0] rb;
    logic [7:0] pause_seq [8];

    repeat (3) @(negedge clk);
    check("reset_hidout", hidout_n, 32'hFFFF_FFFF);
    check("reset_hidfunc", {28'h0, hidfunc}, 32'h0);
    check("reset_rx_err", {31'h0, rx_err}, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1C with latency probe around the stop-bit edge
    send_bits(8'h1C, 1'b0, 10);
    ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("latency_before", hidout_n, 32'hFFFF_FFFF);
    @(negedge clk);
    check("latency_after", hidout_n, 32'hFFFF_FEFF);
    repeat (HALF - 4) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    model_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("release_1c", {31'h0, hidout_n[8]}, 32'h1);
    check("no_err_valid_frames", err_pulses, 0);

    // Extended arrow vs bare keypad code
    send_byte(8'hE0);
    send_byte(8'h75);
    check("e0_75_p0_up", hidout_n, 32'hFFFF_FFFE);
    send_byte(8'h75);
    check("kp8_p1_up", hidout_n, 32'hFFFE_FFFE);
    send_byte(8'hF0);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("arrows_released", hidout_n, 32'hFFFF_FFFF);

    // Parity error
    e0 = err_pulses;
    send_frame(8'h1C, 1'b1);
    check("parity_err_pulse", err_pulses - e0, 1);
    check("parity_err_hid", hidout_n, 32'hFFFF_FFFF);
    send_byte(8'h1C);
    check("after_parity_err", hidout_n, 32'hFFFF_FEFF);
    send_byte(8'hF0);
    send_byte(8'h1C);

    // Stalled frame: start + 5 data bits, then silence
    e0 = err_pulses;
    send_bits(8'h55, 1'b0, 5);
    ps2_dat = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    lat = -1;
    for (int n = 1; n <= 2*TO; n++) begin
      @(negedge clk);
      if (n == HALF) ps2_clk = 1'b1;
      if (rx_err) begin
        lat = n;
        break;
      end
    end
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (4) @(negedge clk);
    check("timeout_window", {31'h0, (lat >= TO && lat <= TO + 5)}, 32'h1);
    check("timeout_err_pulse", err_pulses - e0, 1);
    exp_err++;
    send_byte(8'h1B);
    check("after_timeout_1b", hidout_n, 32'hFFFF_FDFF);
    send_byte(8'hF0);
    send_byte(8'h1B);

    // Pause sequence is swallowed whole
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    foreach (pause_seq[i]) send_byte(pause_seq[i]);
    check("pause_no_change", hidout_n, 32'hFFFF_FFFF);
    send_byte(8'h16);
    check("after_pause_16", hidout_n, 32'hFFFF_EFFF);
    send_byte(8'hF0);
    send_byte(8'h16);

    // Function vector
    send_byte(8'h25);
    send_byte(8'h2B);
    check("hidfunc_rs_t7", {28'h0, hidfunc}, 32'h2);
    send_byte(8'hF0);
    send_byte(8'h2B);
    check("hidfunc_rs_only", {28'h0, hidfunc}, 32'h1);
    send_byte(8'hF0);
    send_byte(8'h25);

    // Random keyboard traffic
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      send_byte(8'hF0);
      else if (r < 20) send_byte(8'hE0);
      else if (r < 22) send_byte(8'hE1);
      else if (r < 26) send_frame(8'($urandom_range(0, 255)), 1'b1);
      else if (r < 32) begin
        rb = 8'($urandom_range(0, 255));
        if (rb == 8'hE0 || rb == 8'hE1 || rb == 8'hF0) rb = 8'h5A;
        send_byte(rb);
      end else begin
        send_byte(tbl[$urandom_range(0, 31)].code);
      end
    end
    check("err_pulse_total", err_pulses, exp_err);
    check("err_pulse_width", long_pulses, 0);

    // Asynchronous reset in the middle of a frame
    while (m_skip > 0) send_byte(8'h00);
    send_byte(8'h25);
    send_bits(8'h16, 1'b0, 4);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_hidout", hidout_n, 32'hFFFF_FFFF);
    check("async_reset_hidfunc", {28'h0, hidfunc}, 32'h0);
    exp_hid = '0;
    m_ext = 1'b0;
    m_rel = 1'b0;
    m_skip = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h16);
    check("after_reset_16", hidout_n, 32'hFFFF_EFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
